// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and round-robin pick for the data-memory arbiter
package dmem_arb_pkg;

    localparam int NUM_REQ_MAX = 4;
    localparam int OWNER_W     = $clog2(NUM_REQ_MAX);
    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_DATA_W  = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } stage_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [OWNER_W-1:0]    owner;
        logic                  we;
        logic [MEM_DATA_W-1:0] rdata;
    } mem_rsp_t;

    // First valid index at or after ptr, wrapping at num; one-hot or zero.
    function automatic logic [NUM_REQ_MAX-1:0] rr_pick(
        input logic [NUM_REQ_MAX-1:0] valid,
        input logic [OWNER_W-1:0]     ptr,
        input logic [OWNER_W:0]       num
    );
        logic [NUM_REQ_MAX-1:0] grant;
        logic [OWNER_W:0]       sum;
        grant = '0;
        for (int k = 0; k < NUM_REQ_MAX; k++) begin
            if ((OWNER_W+1)'(k) < num) begin
                sum = {1'b0, ptr} + (OWNER_W+1)'(k);
                if (sum >= num) begin
                    sum = sum - num;
                end
                if (grant == '0 && valid[sum[OWNER_W-1:0]]) begin
                    grant[sum[OWNER_W-1:0]] = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_grant.sv
// rtl/dmem_arbiter_rr_grant.sv - combinational round-robin grant with registered rotate pointer
module rr_grant
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] grant_idx
);

    logic [OWNER_W-1:0]     ptr_q;
    logic [NUM_REQ_MAX-1:0] pick;
    logic                   any;

    assign pick = rr_pick(NUM_REQ_MAX'(valid), ptr_q, (OWNER_W+1)'(NUM_REQ));
    assign any  = |pick;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ_MAX; i++) begin
            if (pick[i]) begin
                grant_idx = OWNER_W'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any && (grant_idx == OWNER_W'(i));
        end
    end

    // Every grant is a handshake, so the pointer moves past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (any) begin
            ptr_q <= (grant_idx == OWNER_W'(NUM_REQ - 1)) ? '0 : grant_idx + OWNER_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data-memory arbiter, 2-cycle pipeline; DMEM_ARB_STATS_EN adds grant/wait counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_cnt,
    output logic [15:0]               max_wait
`endif
);

    logic [NUM_REQ-1:0] grant;
    logic [OWNER_W-1:0] grant_idx;
    logic               accept;
    mem_req_t           win;

    stage_t             iss_state, iss_next;
    stage_t             rsp_state, rsp_next;
    mem_req_t           iss_q;
    logic [OWNER_W-1:0] iss_owner;
    mem_rsp_t           rsp_q;

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_grant (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // No handshake may complete while reset is asserted.
    assign req_ready = grant & {NUM_REQ{~reset}};
    assign accept    = |req_ready;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win.we    = req_we[i];
                win.addr  = MEM_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
                win.wdata = MEM_DATA_W'(req_wdata[i*DATA_W +: DATA_W]);
            end
        end
    end

    always_comb begin
        iss_next = accept ? ST_VALID : ST_EMPTY;
        rsp_next = (iss_state == ST_VALID) ? ST_VALID : ST_EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_state <= ST_EMPTY;
            rsp_state <= ST_EMPTY;
        end else begin
            iss_state <= iss_next;
            rsp_state <= rsp_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_q     <= '0;
            iss_owner <= '0;
            rsp_q     <= '0;
        end else begin
            if (accept) begin
                iss_q     <= win;
                iss_owner <= grant_idx;
            end
            if (iss_state == ST_VALID) begin
                rsp_q.owner <= iss_owner;
                rsp_q.we    <= iss_q.we;
                rsp_q.rdata <= MEM_DATA_W'(mem_rdata);
            end
        end
    end

    assign mem_we    = (iss_state == ST_VALID) && iss_q.we;
    assign mem_addr  = ADDR_W'(iss_q.addr);
    assign mem_wdata = DATA_W'(iss_q.wdata);

    // rsp_q only changes on a new response, so the masked value holds between pulses.
    assign resp_rdata = rsp_q.we ? '0 : DATA_W'(rsp_q.rdata);

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (rsp_state == ST_VALID) && (rsp_q.owner == OWNER_W'(i));
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gcnt_q   [NUM_REQ];
    logic [15:0] wait_q   [NUM_REQ];
    logic [15:0] wait_nxt [NUM_REQ];
    logic [15:0] max_q;
    logic [15:0] max_nxt;

    always_comb begin
        max_nxt = max_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_nxt[i] = 16'd0;
            if (req_valid[i] && !req_ready[i]) begin
                wait_nxt[i] = (wait_q[i] == 16'hFFFF) ? 16'hFFFF : wait_q[i] + 16'd1;
            end
            if (wait_nxt[i] > max_nxt) begin
                max_nxt = wait_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                gcnt_q[i] <= 16'd0;
                wait_q[i] <= 16'd0;
            end
            max_q <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && gcnt_q[i] != 16'hFFFF) begin
                    gcnt_q[i] <= gcnt_q[i] + 16'd1;
                end
                wait_q[i] <= wait_nxt[i];
            end
            max_q <= max_nxt;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*16 +: 16] = gcnt_q[i];
        end
    end

    assign max_wait = max_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] grant_cnt;
    logic [15:0] max_wait;
`endif

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] rdata;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } wr_exp_t;

    rsp_exp_t    rsp_q[$];
    wr_exp_t     wr_q[$];
    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          gcount [2];
    int          obs_grant [2];
    int          wait_m [2];
    int          max_wait_m;

    dmem_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .max_wait   (max_wait)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = env_mem[mem_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    rsp_exp_t   e;
                    logic [1:0] oh;
                    e  = rsp_q.pop_front();
                    oh = 2'b01 << e.owner;
                    check("resp_owner", 32'(resp_valid), 32'(oh));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_cycle", cyc, e.cyc);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    check("mem_we_unexpected", 32'(mem_we), 32'd0);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check("mem_addr", mem_addr, w.addr);
                    check("mem_wdata", mem_wdata, w.wdata);
                    check("mem_we_cycle", cyc, w.cyc);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic [1:0] exp_rdy);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < 2; i++) begin
            if (req_ready[i]) obs_grant[i]++;
            if (v[i] && !exp_rdy[i]) begin
                wait_m[i]++;
                if (wait_m[i] > max_wait_m) max_wait_m = wait_m[i];
            end else begin
                wait_m[i] = 0;
            end
            if (exp_rdy[i]) begin
                logic [31:0] a;
                logic [31:0] d;
                a = (i == 0) ? a0 : a1;
                d = (i == 0) ? d0 : d1;
                gcount[i]++;
                if (we[i]) begin
                    ref_mem[a[9:2]] = d;
                    rsp_q.push_back('{owner: 2'(i), rdata: 32'd0, cyc: cyc + 2});
                    wr_q.push_back('{addr: a, wdata: d, cyc: cyc + 1});
                end else begin
                    rsp_q.push_back('{owner: 2'(i), rdata: ref_mem[a[9:2]], cyc: cyc + 2});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            env_mem[k] = 32'hC0DE_0000 + 32'(k);
            ref_mem[k] = 32'hC0DE_0000 + 32'(k);
        end
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            gcount[i] = 0;
            obs_grant[i] = 0;
            wait_m[i] = 0;
        end
        max_wait_m = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        // Reset asserted mid-stream with both requesters active.
        step(2'b11, 2'b00, 32'h10, 0, 32'h20, 0, 2'b01);
        step(2'b11, 2'b00, 32'h14, 0, 32'h24, 0, 2'b10);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        rsp_q.delete();
        wr_q.delete();
        for (int i = 0; i < 2; i++) begin
            gcount[i] = 0;
            wait_m[i] = 0;
        end
        max_wait_m = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Both requesters continuously loading: grants alternate starting at 0.
        obs_grant[0] = 0;
        obs_grant[1] = 0;
        for (int k = 0; k < 8; k++) begin
            step(2'b11, 2'b00, 32'h100 + 32'(4*k), 0, 32'h200 + 32'(4*k), 0,
                 (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        check("alt_grants_req0", obs_grant[0], 4);
        check("alt_grants_req1", obs_grant[1], 4);

        // Store then load to the same address from requester 0.
        step(2'b01, 2'b01, 32'h40, 32'hDEADBEEF, 0, 0, 2'b01);
        step(2'b01, 2'b00, 32'h40, 0, 0, 0, 2'b01);
        idle(3);

        // Requester 1 stores, requester 0 loads the same address next cycle.
        step(2'b10, 2'b10, 0, 0, 32'h80, 32'h12345678, 2'b10);
        step(2'b01, 2'b00, 32'h80, 0, 0, 0, 2'b01);
        idle(3);

        // Pointer survives idle cycles: last winner was 0, so 1 wins next.
        step(2'b11, 2'b00, 32'h300, 0, 32'h304, 0, 2'b10);
        step(2'b01, 2'b00, 32'h300, 0, 0, 0, 2'b01);
        idle(4);

        check("rsp_queue_drained", rsp_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
`ifdef DMEM_ARB_STATS_EN
        check("grant_cnt0", 32'(grant_cnt[15:0]), gcount[0]);
        check("grant_cnt1", 32'(grant_cnt[31:16]), gcount[1]);
        check("max_wait", 32'(max_wait), max_wait_m);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Round-robin arbiter that shares the single-port data memory between NUM_REQ requesters, e.g. the core load/store port and a loader/DMA port.
- Each requester uses a valid/ready request handshake and receives a single-cycle response pulse.
- The arbiter registers the winning request, drives the memory for exactly one cycle, captures the read data and returns it two cycles after acceptance.
- Sits between the requesters and the data memory; the memory keeps its combinational read and clocked write.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
ADDR_W, 32, address width.
DATA_W, 32, data width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
req_we  in  NUM_REQ  per-requester write enable (1 = store).
req_addr  in  NUM_REQ x ADDR_W  per-requester address.
req_wdata  in  NUM_REQ x DATA_W  per-requester store data.
resp_valid  out  NUM_REQ  one-cycle completion pulse to the owner.
resp_rdata  out  DATA_W  shared load data, meaningful with resp_valid.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory combinational read data.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, rr_ptr=0, both pipeline stages empty.
- Grant (combinational from req_valid and rr_ptr):
  - Search starts at index rr_ptr, wrapping modulo NUM_REQ; the first valid requester gets req_ready.
  - At most one req_ready is high; none is high when no request is valid.
  - req_ready never depends on downstream state: throughput is one transaction per cycle, no stalls.
- Accept at cycle T (req_valid[i] & req_ready[i]):
  - The issue stage latches {owner=i, we, addr, wdata}.
  - rr_ptr becomes (i+1) mod NUM_REQ.
  - rr_ptr is unchanged on idle cycles.
- Cycle T+1 (issue stage valid):
  - mem_addr/mem_wdata are driven from the issue stage.
  - mem_we = issue.we & issue.valid; mem_we is 0 whenever the issue stage is empty.
  - The response stage latches {owner, we, mem_rdata} at the end of T+1.
- Cycle T+2:
  - resp_valid[owner]=1 for exactly one cycle.
  - resp_rdata = captured mem_rdata for a load, 0 for a store.
  - resp_rdata holds its last value while resp_valid is low.
- Latency: 2 cycles from accept to response, for loads and stores. Responses return in acceptance order.
- Hazard: a store followed by a load to the same address on back-to-back accepts returns the new data, because the memory writes at the end of the store's issue cycle.
- Requester rule: a requester may keep req_valid high across its own outstanding transactions; each handshake is a new transaction. A requester must not change its request fields while valid and not ready.
- Address/data are passed through unmodified; no alignment checks (the memory handles word addressing).
- Reset mid-operation: in-flight transactions are dropped with no resp_valid; mem_we drops to 0 immediately (asynchronous).
- Stage states: issue stage {EMPTY, VALID}; response stage {EMPTY, VALID}; each advances every cycle (pure pipeline, no hold state).

Optional Feature:
DMEM_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ x 16): per-requester count of accepted transactions, saturating at 16'hFFFF.
  - Adds output max_wait (16): longest number of consecutive cycles any requester held req_valid high without req_ready, saturating.
  - Both counters clear on reset.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - NUM_REQ_MAX constant.
  - Typedef mem_req_t {we, addr, wdata}.
  - Typedef mem_rsp_t {owner, we, rdata}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- One natural sub-module: rr_grant (combinational round-robin pick plus registered pointer), reusable by a future instruction-memory arbiter.

Test Plan:
1. Reset asserted mid-stream with both requesters active -> all outputs 0 within the same cycle, no resp_valid after release, first grant goes to requester 0.
2. Only requester 0 valid, store addr 0x40 data 0xDEADBEEF, then load 0x40 on the next cycle -> mem_we=1 for one cycle at T+1; resp_valid[0] at T+2 (rdata 0) and at T+3 (rdata 0xDEADBEEF).
3. Both requesters continuously valid with loads for 8 cycles -> grants alternate 0,1,0,1..., resp_valid alternates with 2-cycle latency, each requester gets 4 grants.
4. Requester 1 store 0x80=0x12345678 accepted at T; requester 0 load 0x80 at T+1 -> load response returns 0x12345678.
5. Idle cycles between requests -> mem_we=0, no resp_valid, rr_ptr unchanged (the next grant follows the last winner+1).
6. With DMEM_ARB_STATS_EN: requester 1 held off for 3 cycles by fixed-pattern traffic -> max_wait=3; grant_cnt matches handshake count; counters saturate when forced past 16'hFFFF.
